// File: rtl/avg_to_bcd_mv.sv
// Scales an averaged ADC code to millivolts, clamps to the displayable range,
// and converts to packed BCD with a serial double-dabble, one bit per clock.
module avg_to_bcd_mv #(
  parameter int IN_W   = 16,
  parameter int SCALE  = 3300,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sat
);

  localparam int BIN_W   = $clog2(10**DIGITS);
  localparam int MV_W    = $clog2(SCALE + 1);
  localparam int PROD_W  = IN_W + MV_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam int BCD_W   = 4 * DIGITS;
  localparam int MAX_VAL = 10**DIGITS - 1;
  localparam int CMP_W   = (MV_W > BIN_W) ? MV_W : BIN_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCALE   = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [IN_W-1:0]  din_q,     din_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic [BCD_W-1:0] bcd_acc_q, bcd_acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             sat_int_q, sat_int_d;
  logic [BCD_W-1:0] bcd_q,     bcd_d;
  logic             sat_q,     sat_d;

  logic [PROD_W-1:0] prod;
  logic [MV_W-1:0]   mv;
  logic [CMP_W-1:0]  mv_ext;
  logic              sat_now;
  logic [BIN_W-1:0]  bin_load;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;

  // Truncating scale: keep only the integer millivolt part of the product.
  assign prod     = PROD_W'(din_q) * PROD_W'(SCALE);
  assign mv       = MV_W'(prod >> IN_W);
  assign mv_ext   = CMP_W'(mv);
  assign sat_now  = mv_ext > CMP_W'(MAX_VAL);
  assign bin_load = sat_now ? BIN_W'(MAX_VAL) : BIN_W'(mv_ext);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_acc_q[4*gi +: 4] >= 4'd5) ?
                                bcd_acc_q[4*gi +: 4] + 4'd3 : bcd_acc_q[4*gi +: 4];
  end

  // The adjusted top bit falls off the end of the shift by construction.
  assign bcd_shift = BCD_W'({bcd_adj, bin_q[BIN_W-1]});

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    bin_d     = bin_q;
    bcd_acc_d = bcd_acc_q;
    cnt_d     = cnt_q;
    sat_int_d = sat_int_q;
    bcd_d     = bcd_q;
    sat_d     = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          din_d   = din;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        bin_d     = bin_load;
        sat_int_d = sat_now;
        bcd_acc_d = '0;
        cnt_d     = '0;
        state_d   = ST_CONVERT;
      end
      ST_CONVERT: begin
        bcd_acc_d = bcd_shift;
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = bcd_shift;
          sat_d   = sat_int_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      bin_q     <= '0;
      bcd_acc_q <= '0;
      cnt_q     <= '0;
      sat_int_q <= 1'b0;
      bcd_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      bin_q     <= bin_d;
      bcd_acc_q <= bcd_acc_d;
      cnt_q     <= cnt_d;
      sat_int_q <= sat_int_d;
      bcd_q     <= bcd_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_avg_to_bcd_mv.sv
// Bench for avg_to_bcd_mv: default-scale and 20000 mV instances, table vectors,
// backpressure, reset aborts, and random codes against an arithmetic model.
module tb_avg_to_bcd_mv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, sat0;
  logic [15:0] din0, bcd0;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, sat1;
  logic [15:0] din1, bcd1;

  avg_to_bcd_mv dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .din(din0), .out_valid(out_valid0), .out_ready(out_ready0), .bcd(bcd0), .sat(sat0)
  );

  avg_to_bcd_mv #(.SCALE(20000)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .din(din1), .out_valid(out_valid1), .out_ready(out_ready1), .bcd(bcd1), .sat(sat1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          w;
    logic [15:0] din;
    logic [15:0] bcd;
    logic        sat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic ir(input bit w);  return w ? in_ready1  : in_ready0;  endfunction
  function automatic logic ov(input bit w);  return w ? out_valid1 : out_valid0; endfunction
  function automatic logic st(input bit w);  return w ? sat1       : sat0;       endfunction
  function automatic logic [15:0] bc(input bit w); return w ? bcd1 : bcd0; endfunction

  task automatic set(input bit w, input logic iv, input logic [15:0] d, input logic ordy);
    if (w) begin
      in_valid1 = iv; din1 = d; out_ready1 = ordy;
    end else begin
      in_valid0 = iv; din0 = d; out_ready0 = ordy;
    end
  endtask

  // Millivolts = floor(code * scale / 2^16), clamped to 9999, as decimal digits.
  function automatic void model(input logic [15:0] d, input int scale,
                                output logic [15:0] eb, output logic es);
    longint mv;
    mv = (longint'(d) * longint'(scale)) / 65536;
    es = (mv > 9999);
    if (es) mv = 9999;
    eb[15:12] = 4'(mv / 1000);
    eb[11:8]  = 4'((mv / 100) % 10);
    eb[7:4]   = 4'((mv / 10) % 10);
    eb[3:0]   = 4'(mv % 10);
  endfunction

  // Starts and ends at a negedge with the selected DUT idle.
  task automatic do_txn(input bit w, input logic [15:0] d, input logic [15:0] eb,
                        input logic es, input int hold, input string nm);
    int lat;
    chk({nm, " in_ready_idle"}, 32'(ir(w)), 32'd1);
    set(w, 1'b1, d, 1'b0);
    @(negedge clk);
    set(w, 1'($urandom), 16'($urandom), 1'b0);
    lat = 0;
    while (ov(w) !== 1'b1 && lat < 40) begin
      chk({nm, " in_ready_busy"}, 32'(ir(w)), 32'd0);
      @(negedge clk);
      lat++;
      set(w, 1'($urandom), 16'($urandom), 1'b0);
    end
    chk({nm, " latency"}, 32'(lat), 32'd15);
    chk({nm, " bcd"}, 32'(bc(w)), 32'(eb));
    chk({nm, " sat"}, 32'(st(w)), 32'(es));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      set(w, 1'($urandom), 16'($urandom), 1'b0);
      chk({nm, " hold_out_valid"}, 32'(ov(w)), 32'd1);
      chk({nm, " hold_bcd"}, 32'(bc(w)), 32'(eb));
      chk({nm, " hold_in_ready"}, 32'(ir(w)), 32'd0);
    end
    set(w, 1'b0, 16'($urandom), 1'b1);
    @(negedge clk);
    set(w, 1'b0, 16'($urandom), 1'b0);
    chk({nm, " out_valid_after_ack"}, 32'(ov(w)), 32'd0);
    chk({nm, " in_ready_after_ack"}, 32'(ir(w)), 32'd1);
    chk({nm, " bcd_retained"}, 32'(bc(w)), 32'(eb));
    chk({nm, " sat_retained"}, 32'(st(w)), 32'(es));
  endtask

  initial begin
    logic [15:0] eb;
    logic        es;
    bit          seen;

    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 0});
    vecs.push_back('{1'b0, 16'h8000, 16'h1650, 1'b0, 20});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h3299, 1'b0, 0});
    vecs.push_back('{1'b0, 16'h0001, 16'h0000, 1'b0, 0});
    vecs.push_back('{1'b0, 16'h1000, 16'h0206, 1'b0, 0});
    vecs.push_back('{1'b0, 16'h4000, 16'h0825, 1'b0, 0});
    vecs.push_back('{1'b0, 16'h0014, 16'h0001, 1'b0, 0});
    vecs.push_back('{1'b1, 16'hFFFF, 16'h9999, 1'b1, 0});
    vecs.push_back('{1'b1, 16'h8000, 16'h9999, 1'b1, 0});
    vecs.push_back('{1'b1, 16'h7FFF, 16'h9999, 1'b0, 0});
    vecs.push_back('{1'b1, 16'h4000, 16'h5000, 1'b0, 0});
    vecs.push_back('{1'b1, 16'h0000, 16'h0000, 1'b0, 0});

    reset = 1'b1;
    set(1'b0, 1'b0, 16'h0, 1'b0);
    set(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset in_ready", 32'(ir(w[0])), 32'd1);
      chk("reset out_valid", 32'(ov(w[0])), 32'd0);
      chk("reset bcd", 32'(bc(w[0])), 32'd0);
      chk("reset sat", 32'(st(w[0])), 32'd0);
    end

    // Reset wins over a simultaneous accept.
    set(1'b0, 1'b1, 16'h8000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    set(1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("reset_vs_accept in_ready", 32'(in_ready0), 32'd1);

    foreach (vecs[i])
      do_txn(vecs[i].w, vecs[i].din, vecs[i].bcd, vecs[i].sat, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset on the 7th CONVERT edge: accept, SCALE edge, six CONVERT edges, then reset.
    set(1'b0, 1'b1, 16'h8000, 1'b0);
    @(negedge clk);
    set(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid0) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_convert no_out_valid", 32'(seen), 32'd0);
    chk("abort_convert bcd", 32'(bcd0), 32'd0);
    chk("abort_convert sat", 32'(sat0), 32'd0);
    chk("abort_convert in_ready", 32'(in_ready0), 32'd1);
    do_txn(1'b0, 16'h8000, 16'h1650, 1'b0, 0, "post_reset");

    // Reset while holding a result in DONE.
    set(1'b1, 1'b1, 16'h4000, 1'b0);
    @(negedge clk);
    set(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (15) @(negedge clk);
    chk("abort_done out_valid_before", 32'(out_valid1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_done out_valid", 32'(out_valid1), 32'd0);
    chk("abort_done bcd", 32'(bcd1), 32'd0);
    chk("abort_done in_ready", 32'(in_ready1), 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      bit          w;
      w = 1'($urandom);
      d = 16'($urandom);
      model(d, w ? 20000 : 3300, eb, es);
      do_txn(w, d, eb, es, int'($urandom_range(0, 3)), $sformatf("rand%0d_d%0h", i, d));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avg_to_bcd_mv.md
AVG_TO_BCD_MV -- requirements
Module: avg_to_bcd_mv

Interface
REQ-001 Parameter IN_W, default 16, width of averaged ADC code input.
REQ-002 Parameter SCALE, default 3300, full-scale value in millivolts corresponding to 2^IN_W.
REQ-003 Parameter DIGITS, default 4, number of BCD output digits.
REQ-004 Derived BIN_W = $clog2(10**DIGITS), which is 14 for DIGITS=4.
REQ-005 clk  input  1  clock; all state changes occur on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  din is valid this cycle.
REQ-008 in_ready  output  1  block can accept din this cycle.
REQ-009 din  input  IN_W  averaged ADC code, unsigned.
REQ-010 out_valid  output  1  bcd/sat hold a new result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 bcd  output  4*DIGITS  packed BCD millivolts; digit 0 is bcd[3:0] (LSD).
REQ-013 sat  output  1  result was clamped to the all-9s value.

Function
REQ-014 The FSM SHALL have four states: IDLE, SCALE, CONVERT and DONE.
REQ-015 in_ready SHALL be 1 in IDLE only and 0 in every other state.
REQ-016 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1: the block latches din and moves to SCALE.
REQ-017 In SCALE, one edge SHALL compute mv = (din * SCALE) >> IN_W as an unsigned product of width IN_W+$clog2(SCALE+1) bits, truncated and not rounded.
REQ-018 If mv > 10**DIGITS-1, the block SHALL substitute 10**DIGITS-1 and set the internal sat flag; otherwise sat SHALL be 0.
REQ-019 In that same SCALE edge, the block SHALL load the BIN_W-bit value into the shift register, clear the BCD accumulator and iteration counter, and move to CONVERT.
REQ-020 CONVERT SHALL perform one double-dabble iteration per edge, for BIN_W edges total.
REQ-021 Each iteration SHALL first add 3 to every BCD digit that is >= 5, then shift {BCD, binary} left by one bit.
REQ-022 On the BIN_W-th CONVERT edge, the block SHALL register the final BCD into bcd, register the flag into sat, and move to DONE.
REQ-023 Latency: out_valid SHALL assert after exactly BIN_W+1 rising edges following the accepting edge (15 for the defaults).
REQ-024 out_valid SHALL be 1 in DONE only.
REQ-025 bcd and sat SHALL be stable while out_valid=1.
REQ-026 In DONE, an edge with out_ready=1 SHALL return the FSM to IDLE; with out_ready=0 the FSM SHALL remain in DONE indefinitely.
REQ-027 The block SHALL NOT accept new input on the same edge as the DONE->IDLE transition; the earliest next acceptance is one edge later.
REQ-028 After the handshake, bcd and sat SHALL retain the last result until the next DONE load, so the display keeps the last value.
REQ-029 in_valid SHALL be ignored in SCALE, CONVERT and DONE; din changes in those states SHALL NOT affect the result in progress.
REQ-030 The iteration counter SHALL be $clog2(BIN_W+1) bits wide and SHALL NOT wrap before CONVERT exits.

Reset
REQ-031 While reset=1 at an edge, the FSM SHALL go to IDLE and clear all internal registers.
REQ-032 While reset=1 at an edge, outputs SHALL be: in_ready=1 after that edge, out_valid=0, bcd=0, sat=0.
REQ-033 Reset SHALL take priority over acceptance and handshake at the same edge.
REQ-034 Reset asserted mid-CONVERT or in DONE SHALL abort the operation; no out_valid pulse SHALL follow.

Verification
REQ-035 The bench SHALL cover: defaults, din=16'h0000 accepted -> after 15 edges out_valid=1, bcd=16'h0000, sat=0.
REQ-036 The bench SHALL cover: din=16'h8000 -> bcd=16'h1650, sat=0.
REQ-037 The bench SHALL cover: din=16'hFFFF -> bcd=16'h3299, sat=0.
REQ-038 The bench SHALL cover: SCALE=20000, din=16'hFFFF -> mv=19999 clamped, bcd=16'h9999, sat=1.
REQ-039 The bench SHALL cover backpressure: out_ready held 0 for 20 cycles after a result -> out_valid and bcd stay constant and in_ready stays 0; raising out_ready -> out_valid=0 next edge, then in_ready=1.
REQ-040 The bench SHALL cover reset mid-run: reset pulsed on the 7th CONVERT edge -> out_valid never asserts, bcd=0, in_ready=1; a following din=16'h8000 yields 16'h1650 with normal latency.
